// File: rtl/ms1004_spi_slave_model_if.sv
// SPI bus between the TDC controller (master) and the MS1004 chip model (slave).
interface ms1004_spi_slave_model_if;
    logic spi_clk;
    logic spi_ssn;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_clk, output spi_ssn, output spi_mosi, input spi_miso);
    modport slave  (input spi_clk, input spi_ssn, input spi_mosi, output spi_miso);
endinterface

// File: rtl/ms1004_spi_slave_model.sv
// MS1004 TDC chip emulation: SPI opcode decoder, config register and hit/interrupt model.
// Define MS1004_MODEL_CFG_READBACK_EN to make opcode 0xB1 return the config word.
module ms1004_spi_slave_model #(
    parameter int INT_LATENCY  = 40,
    parameter int SCK_MIN_HALF = 4
) (
    input  logic                           i_clk_50m,
    input  logic                           i_rst_n,
    input  logic                           i_tdc_reset,
    ms1004_spi_slave_model_if.slave        spi,
    output logic                           o_tdc_intn,
    input  logic                           i_hit,
    input  logic [15:0]                    i_hit_rise,
    input  logic [15:0]                    i_hit_fall,
    input  logic [3:0]                     i_hit_nrise,
    input  logic [3:0]                     i_hit_nfall,
    output logic [31:0]                    o_config,
    output logic                           o_cmd_valid,
    output logic [7:0]                     o_cmd_code,
    output logic                           o_err
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_OPCODE = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_RDATA  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_ARMED = 2'd1;
    localparam logic [1:0] M_WAIT  = 2'd2;
    localparam logic [1:0] M_READY = 2'd3;

    localparam logic [7:0] OP_POR  = 8'h50;
    localparam logic [7:0] OP_INIT = 8'h70;
    localparam logic [7:0] OP_WCFG = 8'h80;
    localparam logic [7:0] OP_STAT = 8'hBD;
    localparam logic [7:0] OP_RISE = 8'hB0;
    localparam logic [7:0] OP_FALL = 8'hC0;
`ifdef MS1004_MODEL_CFG_READBACK_EN
    localparam logic [7:0] OP_RCFG = 8'hB1;
`endif

    localparam logic [9:0] LAT_LAST    = 10'(INT_LATENCY - 1);
    localparam logic [7:0] SCK_GAP_MIN = 8'(SCK_MIN_HALF - 1);

    // [0],[1] form the synchronizer; sck/ssn [2] is the edge-detect register.
    logic [2:0] sck_q, ssn_q;
    logic [1:0] mosi_q;
    logic       sck_rise, sck_fall, ssn_rise, ssn_fall, mosi_bit;

    logic [2:0]  st_q, st_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  op_q, op_d, cmd_q, cmd_d, op_byte;
    logic [31:0] shadow_q, shadow_d, tx_q, tx_d, config_q, config_d;
    logic        miso_q, miso_d, cmd_valid_q, cmd_valid_d, err_q, err_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic        commit_por, commit_init;

    logic [1:0]  m_st_q, m_st_d;
    logic [9:0]  lat_cnt_q, lat_cnt_d;
    logic        intn_q, intn_d;
    logic [15:0] snap_rise_q, snap_rise_d, snap_fall_q, snap_fall_d;
    logic [3:0]  snap_nrise_q, snap_nrise_d, snap_nfall_q, snap_nfall_d;
    logic [7:0]  sck_gap_q;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ssn_rise = ssn_q[1] & ~ssn_q[2];
    assign ssn_fall = ~ssn_q[1] & ssn_q[2];
    assign mosi_bit = mosi_q[1];
    assign op_byte  = {op_q[6:0], mosi_bit};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        cmd_d       = cmd_q;
        shadow_d    = shadow_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        config_d    = config_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        err_d       = 1'b0;
        commit_por  = 1'b0;
        commit_init = 1'b0;
        case (st_q)
            S_IDLE: if (ssn_fall) begin
                st_d  = S_OPCODE;
                cnt_d = '0;
            end
            S_OPCODE: if (ssn_rise) begin
                st_d  = S_IDLE;
                err_d = 1'b1;
            end else if (sck_fall) begin
                op_d  = op_byte;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd7) begin
                    cmd_d = op_byte;
                    cnt_d = '0;
                    st_d  = S_RDATA;
                    case (op_byte)
                        OP_POR, OP_INIT: st_d = S_DONE;
                        OP_WCFG:         st_d = S_WDATA;
                        OP_STAT:         tx_d = {11'b0, snap_nfall_q, snap_nrise_q, 5'b0, 8'b0};
                        OP_RISE:         tx_d = {7'b0, snap_rise_q, 9'b0};
                        OP_FALL:         tx_d = {7'b0, snap_fall_q, 9'b0};
`ifdef MS1004_MODEL_CFG_READBACK_EN
                        OP_RCFG:         tx_d = config_q;
`endif
                        default:         st_d = S_ERR;
                    endcase
                end
            end
            S_WDATA: if (ssn_rise) begin
                st_d = S_IDLE;
                if (cnt_q == 6'd32) begin
                    config_d    = shadow_q;
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = OP_WCFG;
                end else begin
                    err_d = 1'b1;
                end
            end else if (sck_fall) begin
                shadow_d = {shadow_q[30:0], mosi_bit};
                if (cnt_q != '1) cnt_d = cnt_q + 6'd1;
            end
            S_RDATA: if (ssn_rise) begin
                st_d        = S_IDLE;
                cmd_valid_d = 1'b1;
                cmd_code_d  = cmd_q;
            end else if (sck_rise) begin
                miso_d = tx_q[31];
                tx_d   = {tx_q[30:0], 1'b0};
            end
            S_DONE: if (ssn_rise) begin
                st_d        = S_IDLE;
                cmd_valid_d = 1'b1;
                cmd_code_d  = cmd_q;
                if (cmd_q == OP_POR) begin
                    config_d   = '0;
                    commit_por = 1'b1;
                end else begin
                    commit_init = 1'b1;
                end
            end
            S_ERR: if (ssn_rise) begin
                st_d  = S_IDLE;
                err_d = 1'b1;
            end
            default: st_d = S_IDLE;
        endcase
        if (st_d != S_RDATA) miso_d = 1'b0;
        // Chip reset aborts silently: no strobes, config cleared.
        if (!i_tdc_reset) begin
            st_d        = S_IDLE;
            miso_d      = 1'b0;
            config_d    = '0;
            cmd_valid_d = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_comb begin
        m_st_d       = m_st_q;
        lat_cnt_d    = lat_cnt_q;
        intn_d       = intn_q;
        snap_rise_d  = snap_rise_q;
        snap_fall_d  = snap_fall_q;
        snap_nrise_d = snap_nrise_q;
        snap_nfall_d = snap_nfall_q;
        if (!i_tdc_reset || commit_por) begin
            m_st_d = M_IDLE;
            intn_d = 1'b1;
        end else if (commit_init) begin
            m_st_d = M_ARMED;
            intn_d = 1'b1;
        end else begin
            case (m_st_q)
                M_ARMED: if (i_hit) begin
                    snap_rise_d  = i_hit_rise;
                    snap_fall_d  = i_hit_fall;
                    snap_nrise_d = i_hit_nrise;
                    snap_nfall_d = i_hit_nfall;
                    lat_cnt_d    = '0;
                    m_st_d       = M_WAIT;
                end
                M_WAIT: if (lat_cnt_q == LAT_LAST) begin
                    intn_d = 1'b0;
                    m_st_d = M_READY;
                end else begin
                    lat_cnt_d = lat_cnt_q + 10'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_q     <= '0;
            ssn_q     <= '1;
            mosi_q    <= '0;
            sck_gap_q <= '0;
        end else begin
            sck_q     <= {sck_q[1:0], spi.spi_clk};
            ssn_q     <= {ssn_q[1:0], spi.spi_ssn};
            mosi_q    <= {mosi_q[0], spi.spi_mosi};
            if (sck_rise || sck_fall) sck_gap_q <= '0;
            else if (sck_gap_q != '1) sck_gap_q <= sck_gap_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q         <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            cmd_q        <= '0;
            shadow_q     <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            config_q     <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= '0;
            err_q        <= 1'b0;
            m_st_q       <= M_IDLE;
            lat_cnt_q    <= '0;
            intn_q       <= 1'b1;
            snap_rise_q  <= '0;
            snap_fall_q  <= '0;
            snap_nrise_q <= '0;
            snap_nfall_q <= '0;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            cmd_q        <= cmd_d;
            shadow_q     <= shadow_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            config_q     <= config_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            err_q        <= err_d;
            m_st_q       <= m_st_d;
            lat_cnt_q    <= lat_cnt_d;
            intn_q       <= intn_d;
            snap_rise_q  <= snap_rise_d;
            snap_fall_q  <= snap_fall_d;
            snap_nrise_q <= snap_nrise_d;
            snap_nfall_q <= snap_nfall_d;
        end
    end

    // SCK faster than SCK_MIN_HALF cannot be tracked through the synchronizer.
    a_sck_half: assert property (@(posedge i_clk_50m) disable iff (!i_rst_n)
        (sck_rise || sck_fall) |-> (sck_gap_q >= SCK_GAP_MIN));

    assign spi.spi_miso = miso_q;
    assign o_tdc_intn   = intn_q;
    assign o_config     = config_q;
    assign o_cmd_valid  = cmd_valid_q;
    assign o_cmd_code   = cmd_code_q;
    assign o_err        = err_q;
endmodule

// File: tb/tb_ms1004_spi_slave_model.sv
// Randomized bench for the MS1004 model, checked against a transaction-level chip model.
module tb_ms1004_spi_slave_model;
    localparam int INT_LATENCY = 40;
    localparam int HIT_TIMEOUT = 200;

    logic        i_clk_50m = 1'b0;
    logic        i_rst_n, i_tdc_reset, i_hit;
    logic [15:0] i_hit_rise, i_hit_fall;
    logic [3:0]  i_hit_nrise, i_hit_nfall;
    logic        o_tdc_intn, o_cmd_valid, o_err;
    logic [31:0] o_config;
    logic [7:0]  o_cmd_code;

    ms1004_spi_slave_model_if spi_if ();

    ms1004_spi_slave_model #(.INT_LATENCY(INT_LATENCY), .SCK_MIN_HALF(4)) dut (
        .i_clk_50m   (i_clk_50m),
        .i_rst_n     (i_rst_n),
        .i_tdc_reset (i_tdc_reset),
        .spi         (spi_if),
        .o_tdc_intn  (o_tdc_intn),
        .i_hit       (i_hit),
        .i_hit_rise  (i_hit_rise),
        .i_hit_fall  (i_hit_fall),
        .i_hit_nrise (i_hit_nrise),
        .i_hit_nfall (i_hit_nfall),
        .o_config    (o_config),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd_code  (o_cmd_code),
        .o_err       (o_err)
    );

    always #10 i_clk_50m = ~i_clk_50m;

    int total = 0;
    int bad   = 0;

    // Chip model: committed config, captured hit data, and whether a hit would be accepted.
    logic [31:0] m_config;
    logic [15:0] m_rise, m_fall;
    logic [3:0]  m_nrise, m_nfall;
    bit          m_armed;

    function automatic logic [31:0] exp_status();
        return 32'(m_nfall) * 32'd512 + 32'(m_nrise) * 32'd32;
    endfunction

    function automatic logic [31:0] exp_result(input logic [15:0] v);
        return 32'(v) * 32'd512;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk_50m);
        #1;
    endtask

    task automatic send_bit(input logic b, input int h, output logic m);
        spi_if.spi_mosi = b;
        spi_if.spi_clk  = 1'b1;
        tick(h);
        m = spi_if.spi_miso;
        spi_if.spi_clk = 1'b0;
        tick(h);
    endtask

    task automatic ssn_end(output int v_n, output int v_at, output int e_n, output int e_at);
        v_n = 0; v_at = -1; e_n = 0; e_at = -1;
        spi_if.spi_ssn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (o_cmd_valid === 1'b1) begin v_n++; if (v_at < 0) v_at = k; end
            if (o_err === 1'b1) begin e_n++; if (e_at < 0) e_at = k; end
        end
    endtask

    task automatic spi_xfer(input logic [7:0] op, input logic [31:0] wdata, input int nbits,
                            output logic [31:0] rx, output logic op_miso,
                            output int v_n, output int v_at, output int e_n, output int e_at);
        int   h;
        logic m;
        h = $urandom_range(4, 8);
        rx = '0; op_miso = 1'b0;
        spi_if.spi_ssn = 1'b0;
        tick(h);
        for (int i = 0; i < 8; i++) begin send_bit(op[7-i], h, m); op_miso |= m; end
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < 32) ? wdata[31-i] : 1'b0, h, m);
            rx = {rx[30:0], m};
        end
        tick(h);
        ssn_end(v_n, v_at, e_n, e_at);
    endtask

    task automatic pulse_hit(input logic [15:0] r, input logic [15:0] f, input logic [3:0] nr, input logic [3:0] nf);
        i_hit_rise = r; i_hit_fall = f; i_hit_nrise = nr; i_hit_nfall = nf;
        i_hit = 1'b1;
        tick(1);
        i_hit = 1'b0;
        i_hit_rise = 16'($urandom); i_hit_fall = 16'($urandom);
        i_hit_nrise = 4'($urandom); i_hit_nfall = 4'($urandom);
        if (m_armed) begin
            m_rise = r; m_fall = f; m_nrise = nr; m_nfall = nf;
            m_armed = 1'b0;
        end
    endtask

    // Cycles from driving the hit to seeing intn low; HIT_TIMEOUT if it never falls.
    task automatic wait_intn(output int lat);
        lat = 1;
        while (o_tdc_intn === 1'b1 && lat < HIT_TIMEOUT) begin tick(1); lat++; end
    endtask

    task automatic test_reset();
        total++; if (spi_if.spi_miso !== 1'b0) begin bad++; $display("FAIL rst_miso: got %b want 0", spi_if.spi_miso); end
        total++; if (o_tdc_intn !== 1'b1) begin bad++; $display("FAIL rst_intn: got %b want 1", o_tdc_intn); end
        total++; if (o_config !== 32'h0) begin bad++; $display("FAIL rst_config: got %h want 0", o_config); end
        total++; if (o_cmd_valid !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL rst_strobes: valid=%b err=%b want 0 0", o_cmd_valid, o_err); end
        total++; if (o_cmd_code !== 8'h00) begin bad++; $display("FAIL rst_code: got %h want 00", o_cmd_code); end
    endtask

    task automatic test_config_write();
        logic [31:0] w, rx;
        logic om;
        int vn, va, en, ea;
        for (int it = 0; it < 4; it++) begin
            w = (it == 0) ? 32'h224A2450 : $urandom;
            spi_xfer(8'h80, w, 32, rx, om, vn, va, en, ea);
            m_config = w;
            total++; if (vn !== 1 || va !== 3 || en !== 0) begin bad++; $display("FAIL wcfg_strobe: valid=%0d@%0d err=%0d want 1@3 err=0", vn, va, en); end
            total++; if (o_cmd_code !== 8'h80) begin bad++; $display("FAIL wcfg_code: got %h want 80", o_cmd_code); end
            total++; if (o_config !== m_config) begin bad++; $display("FAIL wcfg_value: got %h want %h", o_config, m_config); end
        end
    endtask

    task automatic test_short_write();
        logic [31:0] rx;
        logic om;
        int vn, va, en, ea;
        int lens[3] = '{20, 31, 33};
        for (int it = 0; it < 3; it++) begin
            spi_xfer(8'h80, $urandom, lens[it], rx, om, vn, va, en, ea);
            total++; if (en !== 1 || ea !== 3 || vn !== 0) begin bad++; $display("FAIL short_wr_strobe len=%0d: err=%0d@%0d valid=%0d want err 1@3 valid 0", lens[it], en, ea, vn); end
            total++; if (o_config !== m_config) begin bad++; $display("FAIL short_wr_config len=%0d: got %h want %h", lens[it], o_config, m_config); end
        end
    endtask

    task automatic check_reads(input string tag);
        logic [31:0] rx;
        logic om;
        int vn, va, en, ea;
        spi_xfer(8'hBD, 32'h0, 24, rx, om, vn, va, en, ea);
        total++; if (rx !== exp_status() || vn !== 1 || en !== 0) begin bad++; $display("FAIL %s_status: got %h valid=%0d err=%0d want %h 1 0", tag, rx, vn, en, exp_status()); end
        spi_xfer(8'hB0, 32'h0, 32, rx, om, vn, va, en, ea);
        total++; if (rx !== exp_result(m_rise) || o_cmd_code !== 8'hB0) begin bad++; $display("FAIL %s_rise: got %h code=%h want %h B0", tag, rx, o_cmd_code, exp_result(m_rise)); end
        spi_xfer(8'hC0, 32'h0, 32, rx, om, vn, va, en, ea);
        total++; if (rx !== exp_result(m_fall) || va !== 3) begin bad++; $display("FAIL %s_fall: got %h valid_at=%0d want %h 3", tag, rx, va, exp_result(m_fall)); end
    endtask

    task automatic test_measure();
        logic [31:0] rx;
        logic om;
        int vn, va, en, ea, lat, exp_lat;
        for (int it = 0; it < 3; it++) begin
            spi_xfer(8'h70, 32'h0, 0, rx, om, vn, va, en, ea);
            m_armed = 1'b1;
            total++; if (vn !== 1 || va !== 3 || o_cmd_code !== 8'h70 || o_tdc_intn !== 1'b1) begin bad++; $display("FAIL arm: valid=%0d@%0d code=%h intn=%b want 1@3 70 1", vn, va, o_cmd_code, o_tdc_intn); end
            exp_lat = m_armed ? INT_LATENCY + 1 : HIT_TIMEOUT;
            if (it == 0) pulse_hit(16'h1234, 16'h1300, 4'd1, 4'd1);
            else pulse_hit(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
            wait_intn(lat);
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL intn_latency: got %0d want %0d", lat, exp_lat); end
            pulse_hit(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
            check_reads("meas");
        end
    endtask

    task automatic test_rearm_and_por();
        logic [31:0] rx;
        logic om;
        int vn, va, en, ea, lat;
        spi_xfer(8'h70, 32'h0, 0, rx, om, vn, va, en, ea);
        m_armed = 1'b1;
        total++; if (o_tdc_intn !== 1'b1) begin bad++; $display("FAIL rearm_intn: got %b want 1", o_tdc_intn); end
        spi_xfer(8'h50, 32'h0, 0, rx, om, vn, va, en, ea);
        m_armed = 1'b0; m_config = '0;
        total++; if (o_config !== m_config || o_cmd_code !== 8'h50 || vn !== 1) begin bad++; $display("FAIL por: config=%h code=%h valid=%0d want 0 50 1", o_config, o_cmd_code, vn); end
        pulse_hit(16'hBEEF, 16'hCAFE, 4'd3, 4'd4);
        wait_intn(lat);
        total++; if (lat !== HIT_TIMEOUT) begin bad++; $display("FAIL por_hit_ignored: intn fell after %0d want none", lat); end
        check_reads("por");
    endtask

    task automatic test_hit_at_arm();
        logic m;
        int h, vn, va, en, ea, lat;
        h = $urandom_range(4, 8);
        spi_if.spi_ssn = 1'b0;
        tick(h);
        for (int i = 0; i < 8; i++) send_bit(((8'h70 >> (7 - i)) & 8'h01) != 0, h, m);
        tick(h);
        spi_if.spi_ssn = 1'b1;
        tick(2);
        i_hit = 1'b1;
        tick(1);
        i_hit = 1'b0;
        tick(5);
        wait_intn(lat);
        total++; if (lat !== HIT_TIMEOUT) begin bad++; $display("FAIL hit_at_arm_dropped: intn fell after %0d want none", lat); end
        m_armed = 1'b1;
        pulse_hit(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
        wait_intn(lat);
        total++; if (lat !== INT_LATENCY + 1) begin bad++; $display("FAIL hit_after_arm: got %0d want %0d", lat, INT_LATENCY + 1); end
        check_reads("arm");
    endtask

    task automatic test_bad_opcode();
        logic [31:0] rx;
        logic [7:0]  op;
        logic om, m;
        int vn, va, en, ea, h;
        for (int it = 0; it < 3; it++) begin
            op = 8'h33;
            if (it > 0) begin
                do op = 8'($urandom);
                while (op inside {8'h50, 8'h70, 8'h80, 8'hBD, 8'hB0, 8'hC0, 8'hB1});
            end
            spi_xfer(op, $urandom, 16, rx, om, vn, va, en, ea);
            total++; if (en !== 1 || ea !== 3 || vn !== 0) begin bad++; $display("FAIL bad_op %h strobe: err=%0d@%0d valid=%0d want 1@3 0", op, en, ea, vn); end
            total++; if (rx !== 32'h0 || om !== 1'b0 || spi_if.spi_miso !== 1'b0) begin bad++; $display("FAIL bad_op %h miso: data=%h op_phase=%b want 0", op, rx, om); end
        end
        h = 5;
        spi_if.spi_ssn = 1'b0;
        tick(h);
        for (int i = 0; i < 5; i++) send_bit(1'b1, h, m);
        tick(h);
        ssn_end(vn, va, en, ea);
        total++; if (en !== 1 || vn !== 0 || o_config !== m_config) begin bad++; $display("FAIL partial_opcode: err=%0d valid=%0d config=%h want 1 0 %h", en, vn, o_config, m_config); end
    endtask

    task automatic test_readback();
        logic [31:0] rx, w;
        logic om;
        int vn, va, en, ea;
        w = $urandom;
        spi_xfer(8'h80, w, 32, rx, om, vn, va, en, ea);
        m_config = w;
        spi_xfer(8'hB1, 32'h0, 32, rx, om, vn, va, en, ea);
`ifdef MS1004_MODEL_CFG_READBACK_EN
        total++; if (rx !== m_config || vn !== 1 || en !== 0) begin bad++; $display("FAIL readback: got %h valid=%0d err=%0d want %h 1 0", rx, vn, en, m_config); end
`else
        total++; if (rx !== 32'h0 || vn !== 0 || en !== 1) begin bad++; $display("FAIL readback_off: data=%h valid=%0d err=%0d want 0 0 1", rx, vn, en); end
`endif
    endtask

    task automatic test_tdc_reset();
        logic [31:0] rx, w;
        logic om, m;
        int h, vn, va, en, ea, lat;
        spi_xfer(8'h70, 32'h0, 0, rx, om, vn, va, en, ea);
        m_armed = 1'b1;
        pulse_hit(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
        wait_intn(lat);
        total++; if (lat !== INT_LATENCY + 1) begin bad++; $display("FAIL tdcrst_pre_hit: got %0d want %0d", lat, INT_LATENCY + 1); end
        w = $urandom;
        h = $urandom_range(4, 8);
        spi_if.spi_ssn = 1'b0;
        tick(h);
        for (int i = 0; i < 8; i++) send_bit(((8'h80 >> (7 - i)) & 8'h01) != 0, h, m);
        for (int i = 0; i < 12; i++) send_bit(w[31-i], h, m);
        i_tdc_reset = 1'b0;
        tick(2);
        i_tdc_reset = 1'b1;
        m_config = '0; m_armed = 1'b0;
        for (int i = 12; i < 32; i++) send_bit(w[31-i], h, m);
        tick(h);
        ssn_end(vn, va, en, ea);
        total++; if (en !== 0 || vn !== 0) begin bad++; $display("FAIL tdcrst_strobes: err=%0d valid=%0d want 0 0", en, vn); end
        total++; if (o_config !== m_config || o_tdc_intn !== 1'b1) begin bad++; $display("FAIL tdcrst_state: config=%h intn=%b want %h 1", o_config, o_tdc_intn, m_config); end
        pulse_hit(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
        wait_intn(lat);
        total++; if (lat !== HIT_TIMEOUT) begin bad++; $display("FAIL tdcrst_hit_ignored: intn fell after %0d want none", lat); end
        w = $urandom;
        spi_xfer(8'h80, w, 32, rx, om, vn, va, en, ea);
        m_config = w;
        total++; if (o_config !== m_config || vn !== 1) begin bad++; $display("FAIL tdcrst_recover: config=%h valid=%0d want %h 1", o_config, vn, m_config); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_tdc_reset = 1'b1; i_hit = 1'b0;
        i_hit_rise = '0; i_hit_fall = '0; i_hit_nrise = '0; i_hit_nfall = '0;
        spi_if.spi_clk = 1'b0; spi_if.spi_ssn = 1'b1; spi_if.spi_mosi = 1'b0;
        m_config = '0; m_rise = '0; m_fall = '0; m_nrise = '0; m_nfall = '0; m_armed = 1'b0;
        tick(3);
        i_rst_n = 1'b1;
        tick(2);
        test_reset();
        test_config_write();
        test_short_write();
        test_measure();
        test_rearm_and_por();
        test_hit_at_arm();
        test_bad_opcode();
        test_readback();
        test_tdc_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ms1004_spi_slave_model.md
# ms1004_spi_slave_model

Synthesizable SPI-slave responder that emulates the MS1004 TDC chip as seen by the laser-ranging TDC controller. It sits at the far end of the TDC SPI bus in the sim_w5500 loopback/simulation build. It decodes the controller's opcodes (power-on reset, init, config write, status and result reads), drives MISO and the active-low interrupt, and returns bench-supplied rise/fall timestamps. This lets the controller be exercised without the physical chip.

## Interface
Parameters:
- INT_LATENCY, 40, i_clk_50m cycles from accepted hit to o_tdc_intn assertion (1..1023)
- SCK_MIN_HALF, 4, minimum SCK half-period in i_clk_50m cycles that the model guarantees to track

Ports:
- i_clk_50m  in  1  system clock, 50 MHz
- i_rst_n  in  1  asynchronous, active-low reset
- i_tdc_reset  in  1  chip hardware reset, active low, synchronous effect
- i_spi_clk  in  1  SPI SCK from master, idle low
- i_spi_ssn  in  1  SPI chip select, active low
- i_spi_mosi  in  1  master-to-slave data
- o_spi_miso  out  1  slave-to-master data
- o_tdc_intn  out  1  measurement-ready interrupt, active low
- i_hit  in  1  bench stimulus, one-cycle pulse = laser stop event
- i_hit_rise  in  16  rise timestamp returned by 0xB0
- i_hit_fall  in  16  fall timestamp returned by 0xC0
- i_hit_nrise  in  4  rise hit count reported in status
- i_hit_nfall  in  4  fall hit count reported in status
- o_config  out  32  last committed config word
- o_cmd_valid  out  1  one-cycle strobe when a transaction completes legally
- o_cmd_code  out  8  opcode of the completed transaction
- o_err  out  1  one-cycle strobe on protocol error

## Operation
- i_spi_clk, i_spi_ssn and i_spi_mosi pass through 2-flop synchronizers. Edges are detected on the synchronized signals.
- Bit order is MSB first. MOSI is sampled on the SCK falling edge. MISO is updated on the SCK rising edge.
- MISO is 0 whenever SSN is high or no read is active.
- SPI FSM states:
  - S_IDLE: SSN falling -> S_OPCODE, bit count cleared.
  - S_OPCODE: after 8 bits, decode the opcode.
    - 0x50 and 0x70 -> S_DONE (no payload).
    - 0x80 -> S_WDATA.
    - 0xBD, 0xB0, 0xC0 -> S_RDATA; preload the shift register on the same cycle the 8th bit is sampled.
    - Any other opcode -> S_ERR.
  - S_WDATA: shift 32 bits into a shadow register.
  - S_RDATA: shift the response out. Status (0xBD) is 24 bits. Results (0xB0/0xC0) are 32 bits. Zeros are shifted after the end of the response.
  - S_DONE / S_ERR: wait for SSN rising, then return to S_IDLE.
- Commit on SSN rising edge:
  - Legal transaction: pulse o_cmd_valid, set o_cmd_code.
  - 0x80: o_config <= shadow, only if exactly 32 data bits were received. Otherwise pulse o_err and leave o_config unchanged.
  - 0x50: o_config <= 0, measurement FSM -> M_IDLE, o_tdc_intn <= 1.
  - 0x70: measurement FSM -> M_ARMED, o_tdc_intn <= 1.
- Any SSN rising edge with a partial opcode byte, or from S_ERR: pulse o_err, no state effect.
- Response formats:
  - Status: bits [23:13] = 0, [12:9] = snapshot nfall, [8:5] = snapshot nrise, [4:0] = 0.
  - Result: {7'b0, value[15:0], 9'b0}, so the timestamp occupies bits [24:9].
- Measurement FSM:
  - M_IDLE: i_hit ignored.
  - M_ARMED: on i_hit, snapshot rise, fall, nrise and nfall; go to M_WAIT.
  - M_WAIT: count INT_LATENCY cycles, then assert o_tdc_intn = 0 and go to M_READY.
  - M_READY: further i_hit ignored. Exit only on 0x70 or 0x50.
- Reads in any state return the current snapshot. The snapshot resets to 0.
- i_tdc_reset low has the same effect as 0x50. It also forces the SPI FSM to S_IDLE and aborts any transaction in flight without pulsing o_err.

## Timing
- Reset values: o_spi_miso = 0, o_tdc_intn = 1, o_config = 0, o_cmd_valid = 0, o_cmd_code = 0, o_err = 0. FSMs reset to S_IDLE and M_IDLE.
- Input-edge to internal action latency is 3 cycles (2-flop sync plus edge register).
- MISO changes 3–4 cycles after the SCK rising edge, which is valid for the master provided SCK half-period >= SCK_MIN_HALF.
- o_cmd_valid / o_err assert 3 cycles after the SSN rising edge, for exactly one cycle.
- o_tdc_intn falls exactly INT_LATENCY + 1 cycles after the i_hit pulse. It rises 3 cycles after the SSN rising edge of a 0x70 transaction.
- i_hit coincident with a 0x70 commit is dropped; the arm takes effect on the next cycle.

## Configuration
- MS1004_MODEL_CFG_READBACK_EN:
  - Defined: opcode 0xB1 is legal and returns o_config as a 32-bit read.
  - Undefined: 0xB1 is decoded as unknown -> S_ERR, and the transaction pulses o_err.

## Test plan
- SSN low, send 0x80 + 0x224A2450, SSN high -> o_config = 0x224A2450, o_cmd_valid with o_cmd_code = 0x80, no o_err.
- Send 0x80 + only 20 data bits -> o_err pulse; o_config keeps its old value.
- Send 0x70, then i_hit with rise = 0x1234, fall = 0x1300, nrise = 1, nfall = 1 -> o_tdc_intn low after 41 cycles (INT_LATENCY = 40).
- Continuing: read 0xBD -> 24'h000220. Read 0xB0 -> 32'h00246800. Read 0xC0 -> 32'h00260000.
- Send 0x70 -> o_tdc_intn returns high. Then send 0x50 -> o_config = 0, i_hit ignored, intn stays high.
- Opcode 0x33 -> o_err pulse, MISO stays 0. Drop i_tdc_reset mid-0x80 payload -> FSM returns to idle, no o_err, o_config = 0.
